// File: rtl/data_mem_hs_if.sv
// rtl/data_mem_hs_if.sv - request/response handshake bundle for data_mem_hs
interface data_mem_hs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [STRB_WIDTH-1:0] req_strb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_strb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_strb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_hs.sv
// rtl/data_mem_hs.sv - handshaked word memory with byte-strobe writes and registered reads
// DATA_MEM_INIT_SWEEP_EN adds a post-reset sweep that zeroes every implemented word.
module data_mem_hs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic         clock,
  input  logic         reset_n,
  data_mem_hs_if.slave bus,
  output logic         init_done
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {INIT, RUN} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  accept;
  logic                  in_range;
  logic                  sweep_last;

  // Widened compare so MEM_DEPTH == 2^ADDR_WIDTH does not overflow the constant.
  assign in_range      = {1'b0, bus.req_addr} < (ADDR_WIDTH + 1)'(MEM_DEPTH);
  assign bus.req_ready = (state_q == RUN) && (!rsp_valid_q || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign init_done     = (state_q == RUN);

`ifdef DATA_MEM_INIT_SWEEP_EN
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;

  assign sweep_last = (sweep_q == ADDR_WIDTH'(MEM_DEPTH - 1));
  assign sweep_d    = (state_q == INIT) ? sweep_q + 1'b1 : sweep_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sweep_q <= '0;
    end else begin
      sweep_q <= sweep_d;
    end
  end
`else
  assign sweep_last = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (state_q == INIT && sweep_last) begin
      state_d = RUN;
    end
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !in_range;
      rsp_rdata_d = (in_range && !bus.req_we) ? mem_q[bus.req_addr] : '0;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Array is deliberately outside the reset domain; only the sweep clears it.
  always_ff @(posedge clock) begin
`ifdef DATA_MEM_INIT_SWEEP_EN
    if (reset_n && state_q == INIT) begin
      mem_q[sweep_q] <= '0;
    end
`endif
    if (accept && bus.req_we && in_range) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (bus.req_strb[b]) begin
          mem_q[bus.req_addr][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_data_mem_hs.sv
// tb/tb_data_mem_hs.sv - bench for data_mem_hs: queue-based response model plus directed literal checks
`timescale 1ns/1ps
module tb_data_mem_hs;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 200;
`ifdef DATA_MEM_INIT_SWEEP_EN
  localparam int INIT_LEN = DEPTH;
  localparam bit SWEEP    = 1'b1;
`else
  localparam int INIT_LEN = 1;
  localparam bit SWEEP    = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic init_done;

  data_mem_hs_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  data_mem_hs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .init_done(init_done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    bit            known;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] m_mem   [0:(1<<AW)-1];
  bit            m_known [0:(1<<AW)-1];
  bit            m_run      = 1'b0;
  int            m_init_cnt = 0;
  int            n_rsp      = 0;

  // Model: every accepted request enqueues its response; a consumed response dequeues.
  always @(posedge clock) begin
    rsp_t          r;
    int            a;
    logic [DW-1:0] mask;
    if (reset_n) begin
      if (bus.rsp_valid && bus.rsp_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        n_rsp++;
      end
      if (bus.req_valid && bus.req_ready) begin
        a = int'(bus.req_addr);
        if (a >= DEPTH) begin
          r = '{data: '0, err: 1'b1, known: 1'b1};
        end else if (bus.req_we) begin
          mask = '0;
          for (int b = 0; b < DW/8; b++) if (bus.req_strb[b]) mask[8*b +: 8] = 8'hFF;
          m_mem[a]   = (m_mem[a] & ~mask) | (bus.req_wdata & mask);
          m_known[a] = m_known[a] | (mask == '1);
          r = '{data: '0, err: 1'b0, known: 1'b1};
        end else begin
          r = '{data: m_mem[a], err: 1'b0, known: m_known[a]};
        end
        exp_q.push_back(r);
      end
      if (!m_run) begin
        m_init_cnt++;
        if (m_init_cnt == INIT_LEN) begin
          m_run = 1'b1;
          if (SWEEP) begin
            for (int i = 0; i < DEPTH; i++) begin
              m_mem[i]   = '0;
              m_known[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  always @(negedge reset_n) begin
    exp_q.delete();
    m_run      = 1'b0;
    m_init_cnt = 0;
  end

  always @(negedge clock) begin
    #2;
    if (reset_n) begin
      chk("init_done", init_done, m_run);
      chk("req_ready", bus.req_ready, m_run && (exp_q.size() == 0 || bus.rsp_ready));
      chk("rsp_valid", bus.rsp_valid, exp_q.size() != 0);
      if (bus.rsp_valid && exp_q.size() != 0) begin
        chk("rsp_err", bus.rsp_err, exp_q[0].err);
        if (exp_q[0].known) chk("rsp_rdata", bus.rsp_rdata, exp_q[0].data);
      end
    end
  end

  task automatic drive(input bit we, input int addr, input logic [DW-1:0] wd, input logic [3:0] strb);
    int t;
    t = 0;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr[AW-1:0];
    bus.req_wdata = wd;
    bus.req_strb  = strb;
    #1;
    while (!bus.req_ready) begin
      t++;
      if (t > 200) begin
        chk("accept_timeout", 1'b0, 1'b1);
        bus.req_valid = 1'b0;
        return;
      end
      @(negedge clock);
      #1;
    end
    @(posedge clock);
  endtask

  task automatic idle();
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic single_read(input int addr, input logic [DW-1:0] exp_data, input logic exp_err, input string name);
    drive(1'b0, addr, '0, 4'h0);
    idle();
    #1;
    chk({name, "_valid"}, bus.rsp_valid, 1'b1);
    chk({name, "_data"}, bus.rsp_rdata, exp_data);
    chk({name, "_err"}, bus.rsp_err, exp_err);
  endtask

  task automatic wait_init(input string name);
    int cycles;
    cycles = 0;
    while (!init_done && cycles < 1000) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    chk(name, cycles, INIT_LEN);
  endtask

  initial begin
    int rsp_base;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_rsp_rdata", bus.rsp_rdata, '0);
    chk("reset_rsp_err", bus.rsp_err, 1'b0);
    chk("reset_init_done", init_done, 1'b0);
    chk("reset_req_ready", bus.req_ready, 1'b0);
    reset_n = 1'b1;
    wait_init("init_len");
`ifdef DATA_MEM_INIT_SWEEP_EN
    single_read(DEPTH - 1, 32'h0000_0000, 1'b0, "sweep_zero");
`endif

    // Byte-strobe merge, with the read issued right behind the writes.
    drive(1'b1, 5, 32'hDEAD_BEEF, 4'hF);
    drive(1'b1, 5, 32'h0000_1200, 4'b0010);
    single_read(5, 32'hDEAD_12EF, 1'b0, "strobe_merge");

    for (int i = 0; i < DEPTH; i++) drive(1'b1, i, 32'hC0DE_0000 | i, 4'hF);
    drive(1'b1, 210, 32'hFFFF_FFFF, 4'hF);
    idle();
    #1;
    chk("oor_write_err", bus.rsp_err, 1'b1);
    chk("oor_write_data", bus.rsp_rdata, '0);
    single_read(210, 32'h0, 1'b1, "oor_read");
    single_read(255, 32'h0, 1'b1, "oor_top");
    single_read(DEPTH - 1, 32'hC0DE_00C7, 1'b0, "last_word");
    for (int i = 0; i < DEPTH; i++) drive(1'b0, i, '0, 4'h0);
    idle();

    // Sixteen back-to-back reads with a three-cycle consumer stall in the middle.
    repeat (2) @(negedge clock);
    rsp_base = n_rsp;
    fork
      begin
        for (int i = 0; i < 16; i++) drive(1'b0, i, '0, 4'h0);
        idle();
      end
      begin
        repeat (6) @(negedge clock);
        bus.rsp_ready = 1'b0;
        #1;
        chk("stall_req_ready", bus.req_ready, 1'b0);
        chk("stall_rsp_valid", bus.rsp_valid, 1'b1);
        repeat (3) @(negedge clock);
        bus.rsp_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clock);
    chk("stream_count", n_rsp - rsp_base, 16);

    // Reset while a response is held by backpressure.
    bus.rsp_ready = 1'b0;
    drive(1'b0, 3, '0, 4'h0);
    idle();
    #1;
    chk("held_before_reset", bus.rsp_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_drop", bus.rsp_valid, 1'b0);
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_init("reinit_len");
    single_read(3, SWEEP ? 32'h0 : 32'hC0DE_0003, 1'b0, "after_reset");

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
